// File: rtl/register_file_32x32.sv
// ----------------------------------------------------------------------------
// register_file_32x32
//
// MIPS-style general-purpose register file: 2^ADDR_W registers of DATA_W
// bits. It has two independent combinational read ports and one write port
// that updates on the rising clock edge. Register 0 is hard-wired to zero.
// There is no write-through bypass. A read of the register being written in
// the same cycle returns the old value until the edge.
//
// Ports
//   clk         in   1       single clock; writes happen on its rising edge
//   reset_n     in   1       asynchronous active-low reset, clears all regs
//   RegWrite    in   1       write enable from control
//   write_reg   in   ADDR_W  destination index (from the rt/rd select mux)
//   write_data  in   DATA_W  data to write
//   read_reg1   in   ADDR_W  rs index
//   read_reg2   in   ADDR_W  rt index
//   read_data1  out  DATA_W  contents of register read_reg1
//   read_data2  out  DATA_W  contents of register read_reg2
// ----------------------------------------------------------------------------
module register_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int NUM_REGS = 1 << ADDR_W;

    // Register 0 has no storage at all. It is a constant zero on the read
    // side, so a write to it has nothing to land in.
    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];

    // Next-state: hold everything, then overwrite the addressed entry.
    always_comb begin
        // NOTE: defaulting every output of a combinational block first means
        // no path leaves a value unassigned, so no latch is inferred.
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (RegWrite && (write_reg == ADDR_W'(i))) begin
                regs_d[i] = write_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this storage must be cleared by reset, because the
            // architecture requires every register to read zero straight out
            // of reset. That rules out mapping it onto a RAM macro without
            // a reset; it is built from flops.
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: state updates use non-blocking assignment. Every flop then
            // samples its pre-edge value, and simulation matches hardware.
            regs_q <= regs_d;
        end
    end

    // Combinational read ports. Index 0 falls through to the zero default.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (read_reg1 == ADDR_W'(i)) begin
                read_data1 = regs_q[i];
            end
            if (read_reg2 == ADDR_W'(i)) begin
                read_data2 = regs_q[i];
            end
        end
    end

endmodule

// File: tb/tb_register_file_32x32.sv
// ----------------------------------------------------------------------------
// tb_register_file_32x32
//
// Directed, table-driven bench for register_file_32x32. Each table record
// holds one write request and two read indices. It also holds the read data
// expected just before the edge and just after it. Hand-written sequences
// follow the table and cover these cases:
//   - the full 1..31 sweep
//   - glitches on the write inputs between edges
//   - asynchronous reset with a pending write
//   - the first write after reset is released
// ----------------------------------------------------------------------------
module tb_register_file_32x32;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset_n;
    logic              RegWrite;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    int tests_run = 0;
    int tests_failed = 0;

    register_file_32x32 #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .RegWrite  (RegWrite),
        .write_reg (write_reg),
        .write_data(write_data),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic              we;
        logic [ADDR_W-1:0] wreg;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] rr1;
        logic [ADDR_W-1:0] rr2;
        logic [DATA_W-1:0] pre1;
        logic [DATA_W-1:0] pre2;
        logic [DATA_W-1:0] post1;
        logic [DATA_W-1:0] post2;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [DATA_W-1:0] actual,
                         input logic [DATA_W-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Read both ports at one index and compare against the same expected value.
    task automatic check_index(input string name, input int idx,
                               input logic [DATA_W-1:0] expected);
        read_reg1 = ADDR_W'(idx);
        read_reg2 = ADDR_W'(idx);
        #1;
        check($sformatf("%s_p1_r%0d", name, idx), read_data1, expected);
        check($sformatf("%s_p2_r%0d", name, idx), read_data2, expected);
    endtask

    initial begin
        // Record fields: name, we, wreg, wdata, rr1, rr2, pre1, pre2, post1, post2
        vecs[0] = '{"wr_r8",      1'b1, 5'd8,  32'hDEADBEEF, 5'd8, 5'd31,
                    32'h0,        32'h0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{"wr_r31",     1'b1, 5'd31, 32'h12345678, 5'd8, 5'd31,
                    32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h12345678};
        vecs[2] = '{"wr_r0",      1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd8,
                    32'h0,        32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[3] = '{"we_off_r5",  1'b0, 5'd5,  32'hAAAA5555, 5'd5, 5'd5,
                    32'h0,        32'h0, 32'h0, 32'h0};
        vecs[4] = '{"wr_r9_a",    1'b1, 5'd9,  32'h11111111, 5'd9, 5'd0,
                    32'h0,        32'h0, 32'h11111111, 32'h0};
        vecs[5] = '{"rdw_r9",     1'b1, 5'd9,  32'h22222222, 5'd9, 5'd9,
                    32'h11111111, 32'h11111111, 32'h22222222, 32'h22222222};

        reset_n    = 1'b0;
        RegWrite   = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;

        // Reset state: every index reads zero while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) check_index("reset", i, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: drive at negedge, check before the rising edge, then after it.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            RegWrite   = vecs[v].we;
            write_reg  = vecs[v].wreg;
            write_data = vecs[v].wdata;
            read_reg1  = vecs[v].rr1;
            read_reg2  = vecs[v].rr2;
            #1;
            check({vecs[v].name, "_pre1"}, read_data1, vecs[v].pre1);
            check({vecs[v].name, "_pre2"}, read_data2, vecs[v].pre2);
            @(posedge clk);
            #1;
            check({vecs[v].name, "_post1"}, read_data1, vecs[v].post1);
            check({vecs[v].name, "_post2"}, read_data2, vecs[v].post2);
        end

        // Glitches between edges: toggle the write inputs, then settle with
        // RegWrite=0 before the edge. Register 8 must be unaffected.
        @(negedge clk);
        RegWrite   = 1'b1;
        write_reg  = 5'd8;
        write_data = 32'h0BADF00D;
        #1;
        write_reg  = 5'd12;
        #1;
        RegWrite   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_index("glitch", 8, 32'hDEADBEEF);
        check_index("glitch", 12, 32'h0);

        // Exhaustive sweep: reg i <= i * 0x01010101, then read all indices.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            RegWrite   = 1'b1;
            write_reg  = ADDR_W'(i);
            write_data = DATA_W'(i) * 32'h01010101;
        end
        @(negedge clk);
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) check_index("sweep", i, DATA_W'(i) * 32'h01010101);

        // Async reset between edges with a write pending: it clears at once,
        // and the writes seen on later edges while it is held are ignored.
        @(negedge clk);
        RegWrite   = 1'b1;
        write_reg  = 5'd3;
        write_data = 32'h5A5A5A5A;
        #1;
        reset_n = 1'b0;
        #1;
        check("async_clr_r3_p1", read_data1, 32'h0);
        for (int i = 0; i < 32; i++) check_index("in_reset", i, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_index("reset_hold", 3, 32'h0);

        // Release reset. The first edge with RegWrite=1 is a normal write.
        RegWrite = 1'b0;
        reset_n  = 1'b1;
        #1;
        check_index("post_release", 3, 32'h0);
        @(negedge clk);
        RegWrite   = 1'b1;
        write_reg  = 5'd3;
        write_data = 32'hCAFEF00D;
        read_reg1  = 5'd3;
        read_reg2  = 5'd4;
        #1;
        check("first_wr_pre", read_data1, 32'h0);
        @(posedge clk);
        #1;
        check("first_wr_post", read_data1, 32'hCAFEF00D);
        check("first_wr_other", read_data2, 32'h0);
        @(negedge clk);
        RegWrite = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file_32x32.md
REGISTER_FILE_32X32 -- requirements
Module: register_file_32x32

Interface
Parameters:
REQ-001 SHALL provide parameter DATA_W, default 32, register and data width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width; the register count is 2^ADDR_W = 32.
Ports (name, direction, width, meaning):
REQ-003 SHALL provide port clk, input, 1, the single clock; all writes occur on its rising edge.
REQ-004 SHALL provide port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide port RegWrite, input, 1, write enable from control.
REQ-006 SHALL provide port write_reg, input, ADDR_W, destination register index; this is the output of the upstream rt/rd destination-select mux.
REQ-007 SHALL provide port write_data, input, DATA_W, data to be written.
REQ-008 SHALL provide port read_reg1, input, ADDR_W, rs index.
REQ-009 SHALL provide port read_reg2, input, ADDR_W, rt index.
REQ-010 SHALL provide port read_data1, output, DATA_W, contents of register read_reg1.
REQ-011 SHALL provide port read_data2, output, DATA_W, contents of register read_reg2.
REQ-012 The block SHALL have one clock, clk; reset_n is asynchronous and active-low.

Function
REQ-013 SHALL hold 32 registers of DATA_W bits each, indexed 0..31.
REQ-014 Reads SHALL be combinational with zero-cycle latency: read_dataN = reg[read_regN] whenever read_regN or the register contents change.
REQ-015 On a rising edge of clk with RegWrite=1 and write_reg!=0, reg[write_reg] SHALL take write_data; the new value is visible on the read ports after that edge.
REQ-016 With RegWrite=0, no register SHALL change.
REQ-017 Register 0 SHALL always read 0; a write addressed to 0 is discarded, with no storage change and no side effect.
REQ-018 Same-cycle read and write of the same index SHALL return the old value until the edge, then the new value; there is no write-through bypass.
REQ-019 Both read ports SHALL be independent; read_reg1 == read_reg2 yields identical data on both outputs.
REQ-020 write_reg, write_data and RegWrite SHALL be sampled only at the rising edge; glitches between edges have no effect.
REQ-021 X on RegWrite at an edge SHALL NOT be relied upon; verification treats this as illegal stimulus.

Reset
REQ-022 reset_n=0 SHALL immediately, without waiting for clk, clear all 32 registers to 0; read_data1 and read_data2 read 0 for any address.
REQ-023 While reset_n=0, writes SHALL be ignored regardless of RegWrite.
REQ-024 Reset asserted mid-cycle SHALL override a write pending for the next edge, so the register stays 0.
REQ-025 After reset_n rises, the first rising edge of clk with RegWrite=1 SHALL perform a normal write.

Verification
REQ-026 Reset: pulse reset_n low between edges after registers are loaded -> read_data1 and read_data2 read 0x00000000 for every index 0..31 immediately, before the next clk edge.
REQ-027 Basic write/read: write 0xDEADBEEF to reg 8, then 0x12345678 to reg 31 -> read_reg1=8 gives 0xDEADBEEF and read_reg2=31 gives 0x12345678 in the cycle after each edge.
REQ-028 Zero register: RegWrite=1, write_reg=0, write_data=0xFFFFFFFF -> read_data1 reads 0 with read_reg1=0; registers 1..31 are unchanged.
REQ-029 Write disabled: RegWrite=0, write_reg=5, write_data=0xAAAA5555 -> reg 5 keeps its previous value, 0 after reset.
REQ-030 Read-during-write: reg 9=0x11111111, then write 0x22222222 to 9 with read_reg1=9 -> 0x11111111 before the edge and 0x22222222 after it.
REQ-031 Exhaustive sweep: write value (i*0x01010101) to each i=1..31, then read all indices on both ports -> every value matches; index 0 reads 0.
